// File: rtl/vga_timing_pkg.sv
// Shared constants, region encoding and helpers for the VGA raster timing generator.
// Defaults describe the classic 640x480 @ 60 Hz mode on a 25 MHz pixel rate.
package vga_timing_pkg;

   localparam int DEF_H_DISP = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_DISP = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;
   localparam int DEF_CW     = 10;

   typedef enum logic [1:0] {
      REGION_DISP = 2'd0,
      REGION_FP   = 2'd1,
      REGION_SYNC = 2'd2,
      REGION_BP   = 2'd3
   } region_t;

   function automatic int axis_total(input int disp, input int fp, input int sync, input int bp);
      return disp + fp + sync + bp;
   endfunction

   // True when an unsigned counter of 'width' bits can reach 'value'.
   function automatic bit fits_width(input int value, input int width);
      return (width >= 31) || ((value >> width) == 0);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with display/porch/sync region decode.
// The horizontal instance's wrap flag gates the vertical instance's advance.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int DISP = DEF_H_DISP,
   parameter int FP   = DEF_H_FP,
   parameter int SYNC = DEF_H_SYNC,
   parameter int BP   = DEF_H_BP,
   parameter bit POL  = 1'b0,
   parameter int CW   = DEF_CW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          adv,
   output logic [CW-1:0] cnt,
   output logic          wrap,
   output region_t       region,
   output logic          sync_lvl
);

   localparam int TOTAL = axis_total(DISP, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] FP_START   = CW'(DISP);
   localparam logic [CW-1:0] SYNC_START = CW'(DISP + FP);
   localparam logic [CW-1:0] BP_START   = CW'(DISP + FP + SYNC);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          last_w;

   assign last_w = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (adv) begin
         cnt_d = last_w ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      region = REGION_BP;
      if (cnt_q < FP_START) begin
         region = REGION_DISP;
      end else if (cnt_q < SYNC_START) begin
         region = REGION_FP;
      end else if (cnt_q < BP_START) begin
         region = REGION_SYNC;
      end
   end

   assign cnt      = cnt_q;
   assign wrap     = last_w;
   assign sync_lvl = (region == REGION_SYNC) ? POL : !POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-rate enable and registered strobes.
// Optional feature macro: VGA_TIMING_LOOKAHEAD_EN adds next_x/next_y/next_de lookahead ports.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISP     = DEF_H_DISP,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_DISP     = DEF_V_DISP,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CW         = DEF_CW
) (
   input  logic          new_clk_25,
   input  logic          reset_n,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          pix_valid,
   output logic          line_start,
   output logic          frame_start,
   output logic [CW-1:0] xpos,
   output logic [CW-1:0] ypos
`ifdef VGA_TIMING_LOOKAHEAD_EN
   ,
   output logic [CW-1:0] next_x,
   output logic [CW-1:0] next_y,
   output logic          next_de
`endif
);

   localparam int H_TOTAL = axis_total(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_DISP, V_FP, V_SYNC, V_BP);

   generate
      if (H_DISP < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_DISP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
         $error("vga_timing_gen: every display, porch and sync width must be at least 1");
      end
      if (!fits_width(H_TOTAL - 1, CW) || !fits_width(V_TOTAL - 1, CW)) begin : g_bad_cw
         $error("vga_timing_gen: CW too narrow for the raster totals");
      end
   endgenerate

   logic [CW-1:0] hn;
   logic [CW-1:0] vn;
   logic          h_wrap;
   logic          v_wrap;
   logic          v_adv;
   region_t       h_region;
   region_t       v_region;
   logic          h_sync_lvl;
   logic          v_sync_lvl;
   logic          next_disp;

   assign v_adv = pix_en && h_wrap;

   vga_axis_counter #(
      .DISP (H_DISP),
      .FP   (H_FP),
      .SYNC (H_SYNC),
      .BP   (H_BP),
      .POL  (H_SYNC_POL),
      .CW   (CW)
   ) u_h_axis (
      .clk      (new_clk_25),
      .reset_n  (reset_n),
      .adv      (pix_en),
      .cnt      (hn),
      .wrap     (h_wrap),
      .region   (h_region),
      .sync_lvl (h_sync_lvl)
   );

   vga_axis_counter #(
      .DISP (V_DISP),
      .FP   (V_FP),
      .SYNC (V_SYNC),
      .BP   (V_BP),
      .POL  (V_SYNC_POL),
      .CW   (CW)
   ) u_v_axis (
      .clk      (new_clk_25),
      .reset_n  (reset_n),
      .adv      (v_adv),
      .cnt      (vn),
      .wrap     (v_wrap),
      .region   (v_region),
      .sync_lvl (v_sync_lvl)
   );

   assign next_disp = (h_region == REGION_DISP) && (v_region == REGION_DISP);

   // frame_pend marks that (hn, vn) sits at (0,0): set by reset or by a full-frame wrap,
   // which saves a second zero compare on the vertical counter.
   logic frame_pend_q;
   logic frame_pend_d;

   always_comb begin
      frame_pend_d = frame_pend_q;
      if (pix_en) begin
         frame_pend_d = h_wrap && v_wrap;
      end
   end

   logic [CW-1:0] xpos_q, xpos_d;
   logic [CW-1:0] ypos_q, ypos_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          pix_valid_q, pix_valid_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;

   always_comb begin
      xpos_d        = xpos_q;
      ypos_d        = ypos_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      pix_valid_d   = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (pix_en) begin
         xpos_d        = hn;
         ypos_d        = vn;
         hsync_d       = h_sync_lvl;
         vsync_d       = v_sync_lvl;
         de_d          = next_disp;
         pix_valid_d   = 1'b1;
         line_start_d  = (hn == '0);
         frame_start_d = frame_pend_q;
      end
   end

   always_ff @(posedge new_clk_25) begin
      if (!reset_n) begin
         xpos_q        <= '0;
         ypos_q        <= '0;
         hsync_q       <= !H_SYNC_POL;
         vsync_q       <= !V_SYNC_POL;
         de_q          <= 1'b0;
         pix_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_pend_q  <= 1'b1;
      end else begin
         xpos_q        <= xpos_d;
         ypos_q        <= ypos_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         pix_valid_q   <= pix_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_pend_q  <= frame_pend_d;
      end
   end

   assign xpos        = xpos_q;
   assign ypos        = ypos_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign pix_valid   = pix_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
   // Position that the next pix_en will present, for a one-cycle frame-buffer read.
   assign next_x  = hn;
   assign next_y  = vn;
   assign next_de = next_disp;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 14x7 raster, with a pixel-count model.
// Two instances share stimulus: active-low syncs (dut) and active-high syncs (dut_p).
module tb_vga_timing_gen;

   localparam int HD = 8, HF = 2, HS = 2, HB = 2;
   localparam int VD = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          pix_en;

   logic          hsync, vsync, de, pix_valid, line_start, frame_start;
   logic [CW-1:0] xpos, ypos;
   logic          hsync_p, vsync_p, de_p, pix_valid_p, line_start_p, frame_start_p;
   logic [CW-1:0] xpos_p, ypos_p;
`ifdef VGA_TIMING_LOOKAHEAD_EN
   logic [CW-1:0] next_x, next_y, next_x_p, next_y_p;
   logic          next_de, next_de_p;
`endif

   int errors = 0;
   int checks = 0;

   // Model state: number of pixels presented since reset, and whether one was presented last edge.
   int k = 0;
   bit pv_m = 1'b0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(CW)
   ) dut (
      .new_clk_25  (clk),
      .reset_n     (reset_n),
      .pix_en      (pix_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .pix_valid   (pix_valid),
      .line_start  (line_start),
      .frame_start (frame_start),
      .xpos        (xpos),
      .ypos        (ypos)
`ifdef VGA_TIMING_LOOKAHEAD_EN
      ,
      .next_x      (next_x),
      .next_y      (next_y),
      .next_de     (next_de)
`endif
   );

   vga_timing_gen #(
      .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(CW)
   ) dut_p (
      .new_clk_25  (clk),
      .reset_n     (reset_n),
      .pix_en      (pix_en),
      .hsync       (hsync_p),
      .vsync       (vsync_p),
      .de          (de_p),
      .pix_valid   (pix_valid_p),
      .line_start  (line_start_p),
      .frame_start (frame_start_p),
      .xpos        (xpos_p),
      .ypos        (ypos_p)
`ifdef VGA_TIMING_LOOKAHEAD_EN
      ,
      .next_x      (next_x_p),
      .next_y      (next_y_p),
      .next_de     (next_de_p)
`endif
   );

   always @(posedge clk) begin
      if (!reset_n) begin
         k    <= 0;
         pv_m <= 1'b0;
      end else if (pix_en) begin
         k    <= k + 1;
         pv_m <= 1'b1;
      end else begin
         pv_m <= 1'b0;
      end
   end

   function automatic int pos_x(input int kk);
      return (kk == 0) ? 0 : (kk - 1) % HT;
   endfunction

   function automatic int pos_y(input int kk);
      return (kk == 0) ? 0 : ((kk - 1) / HT) % VT;
   endfunction

   function automatic bit in_hsync(input int x);
      return (x >= HD + HF) && (x < HD + HF + HS);
   endfunction

   function automatic bit in_vsync(input int y);
      return (y >= VD + VF) && (y < VD + VF + VS);
   endfunction

   task automatic check_sig(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input bit rst_n, input bit en);
      reset_n = rst_n;
      pix_en  = en;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_output();
      int x, y;
      bit dexp;
      x    = pos_x(k);
      y    = pos_y(k);
      dexp = (k > 0) && (x < HD) && (y < VD);
      check_sig("xpos", 32'(xpos), x);
      check_sig("ypos", 32'(ypos), y);
      check_sig("de", 32'(de), 32'(dexp));
      check_sig("pix_valid", 32'(pix_valid), 32'(pv_m));
      check_sig("line_start", 32'(line_start), 32'(pv_m && x == 0));
      check_sig("frame_start", 32'(frame_start), 32'(pv_m && x == 0 && y == 0));
      check_sig("hsync", 32'(hsync), 32'(!in_hsync(x)));
      check_sig("vsync", 32'(vsync), 32'(!in_vsync(y)));
      check_sig("hsync_pol1", 32'(hsync_p), 32'(in_hsync(x)));
      check_sig("vsync_pol1", 32'(vsync_p), 32'(in_vsync(y)));
      check_sig("frame_start_pol1", 32'(frame_start_p), 32'(pv_m && x == 0 && y == 0));
`ifdef VGA_TIMING_LOOKAHEAD_EN
      check_sig("next_x", 32'(next_x), k % HT);
      check_sig("next_y", 32'(next_y), (k / HT) % VT);
      check_sig("next_de", 32'(next_de), 32'(((k % HT) < HD) && (((k / HT) % VT) < VD)));
      check_sig("next_x_pol1", 32'(next_x_p), k % HT);
`endif
   endtask

   task automatic run_to(input int tx, input int ty);
      for (int i = 0; i < 2 * HT * VT; i++) begin
         if (pv_m && pos_x(k) == tx && pos_y(k) == ty) break;
         apply_stimulus(1'b1, 1'b1);
         check_output();
      end
      check_sig($sformatf("reach_x_%0d_%0d", tx, ty), 32'(xpos), tx);
      check_sig($sformatf("reach_y_%0d_%0d", tx, ty), 32'(ypos), ty);
   endtask

   // Clocks between consecutive strobes with pix_en held high.
   task automatic measure_period(input string name, input bit use_frame, input int exp_p);
      int n;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !seen; i++) begin
         apply_stimulus(1'b1, 1'b1);
         seen = use_frame ? frame_start : line_start;
      end
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !seen; i++) begin
         apply_stimulus(1'b1, 1'b1);
         n++;
         seen = use_frame ? frame_start : line_start;
      end
      check_sig(name, seen ? n : -1, exp_p);
   endtask

   typedef struct {
      bit rst_n;
      bit en;
      int x;
      int y;
      bit hs;
      bit vs;
      bit de;
      bit pv;
      bit ls;
      bit fs;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      reset_n = 1'b0;
      pix_en  = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i].rst_n, vecs[i].en);
         check_sig($sformatf("vec%0d xpos", i), 32'(xpos), vecs[i].x);
         check_sig($sformatf("vec%0d ypos", i), 32'(ypos), vecs[i].y);
         check_sig($sformatf("vec%0d hsync", i), 32'(hsync), 32'(vecs[i].hs));
         check_sig($sformatf("vec%0d vsync", i), 32'(vsync), 32'(vecs[i].vs));
         check_sig($sformatf("vec%0d hsync_pol1", i), 32'(hsync_p), 32'(!vecs[i].hs));
         check_sig($sformatf("vec%0d de", i), 32'(de), 32'(vecs[i].de));
         check_sig($sformatf("vec%0d pix_valid", i), 32'(pix_valid), 32'(vecs[i].pv));
         check_sig($sformatf("vec%0d line_start", i), 32'(line_start), 32'(vecs[i].ls));
         check_sig($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
         check_output();
      end

      $display("[TB] line wrap at (13,2)");
      run_to(13, 2);
      apply_stimulus(1'b1, 1'b1);
      check_sig("wrap_line xpos", 32'(xpos), 0);
      check_sig("wrap_line ypos", 32'(ypos), 3);
      check_sig("wrap_line line_start", 32'(line_start), 1);
      check_sig("wrap_line frame_start", 32'(frame_start), 0);

      $display("[TB] frame wrap at (13,6)");
      run_to(13, 6);
      apply_stimulus(1'b1, 1'b1);
      check_sig("wrap_frame xpos", 32'(xpos), 0);
      check_sig("wrap_frame ypos", 32'(ypos), 0);
      check_sig("wrap_frame frame_start", 32'(frame_start), 1);
      check_sig("wrap_frame line_start", 32'(line_start), 1);

      $display("[TB] pix_en every 4th clock");
      for (int i = 0; i < 64; i++) begin
         apply_stimulus(1'b1, (i % 4) == 0);
         check_output();
      end

      $display("[TB] mid-frame reset at (5,2)");
      run_to(5, 2);
      apply_stimulus(1'b0, 1'b1);
      check_sig("mid_reset xpos", 32'(xpos), 0);
      check_sig("mid_reset ypos", 32'(ypos), 0);
      check_sig("mid_reset de", 32'(de), 0);
      check_sig("mid_reset hsync", 32'(hsync), 1);
      check_sig("mid_reset vsync_pol1", 32'(vsync_p), 0);
      check_sig("mid_reset pix_valid", 32'(pix_valid), 0);
      check_sig("mid_reset frame_start", 32'(frame_start), 0);
      apply_stimulus(1'b1, 1'b0);
      check_output();
      apply_stimulus(1'b1, 1'b1);
      check_sig("restart xpos", 32'(xpos), 0);
      check_sig("restart ypos", 32'(ypos), 0);
      check_sig("restart de", 32'(de), 1);
      check_sig("restart frame_start", 32'(frame_start), 1);
      check_sig("restart line_start", 32'(line_start), 1);

      $display("[TB] periods with pix_en high");
      measure_period("line_period", 1'b0, HT);
      measure_period("frame_period", 1'b1, HT * VT);

      $display("[TB] randomized stimulus");
      for (int i = 0; i < 800; i++) begin
         apply_stimulus($urandom_range(0, 99) != 0, $urandom_range(0, 2) != 0);
         check_output();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
